// File: rtl/rv_pkg.sv
// Types and constants shared by the instruction fetch unit and its fetch buffer.
package rv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer between the instruction memory and decode.
module fetch_fifo
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      // flush wins over any pop or push presented in the same cycle
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, RUN/FAULT control, legality check and a
// two-entry buffer presenting {pc, instr} to decode. WIDTH must equal XLEN.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] iaddr,
  input  logic [WIDTH-1:0] instr,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc
);

  fetch_state_t     state, state_nxt;
  logic [WIDTH-1:0] pc;
  logic             legal;
  logic             pop;
  logic             fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  assign iaddr     = pc;
  assign legal     = (pc[1:0] == 2'b00) && ((pc >> 2) < WIDTH'(DEPTH));
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : head.pc;
  assign out_instr = fifo_empty ? '0 : head.instr;
  assign fault     = (state == FAULT);
  assign pop       = out_valid && out_ready && !redir_valid;
  assign push_data = '{pc: pc, instr: instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    if (redir_valid) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!legal)                      state_nxt = FAULT;
          else if (!fifo_full || pop)      fire      = 1'b1;
        end
        FAULT: state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else if (redir_valid) begin
      pc       <= redir_pc;
      fault_pc <= '0;
    end else begin
      if (fire) pc <= pc + WIDTH'(INSTR_BYTES);
      if (state == RUN && !legal) fault_pc <= pc;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redir_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized
// redirects/backpressure checked against a queue-based reference model.
module tb_ifetch_unit;

  localparam int          DEPTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iaddr, instr, redir_pc, out_pc, out_instr, fault_pc;
  logic        redir_valid, out_valid, out_ready, fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] imem [0:DEPTH-1];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fpc;

  always #5 clk = ~clk;

  ifetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .instr(instr),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .fault(fault), .fault_pc(fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (w < DEPTH) return imem[w];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb instr = mem_word(iaddr);

  function automatic logic pc_ok(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_fpc   = '0;
  endtask

  task automatic do_reset();
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic do_pop;
    redir_valid = rv;
    redir_pc    = rpc;
    out_ready   = rdy;
    @(posedge clk);
    if (rv) begin
      mq.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
      m_fpc   = '0;
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (!m_fault && !pc_ok(m_pc)) begin
        m_fault = 1'b1;
        m_fpc   = m_pc;
      end else if (!m_fault && mq.size() < 2) begin
        mq.push_back('{pc: m_pc, ins: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (iaddr !== RESET_PC || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 ||
        fault !== 1'b0 || fault_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: iaddr=%h out_valid=%b out_pc=%h out_instr=%h fault=%b fault_pc=%h, expected %h 0 0 0 0 0",
               iaddr, out_valid, out_pc, out_instr, fault, fault_pc, RESET_PC);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [31:0] exp_ins [4];
    exp_ins[0] = 32'h11; exp_ins[1] = 32'h22; exp_ins[2] = 32'h33; exp_ins[3] = 32'h44;
    for (int i = 0; i < 4; i++) imem[i] = exp_ins[i];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== exp_ins[k] || iaddr !== 32'(4 * k + 4)) begin
        n_bad++;
        $display("FAIL stream beat %0d: valid=%b pc=%h instr=%h iaddr=%h, expected 1 %h %h %h",
                 k, out_valid, out_pc, out_instr, iaddr, 4 * k, exp_ins[k], 4 * k + 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    do_reset();
    cyc(1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || iaddr !== 32'h8) begin
        n_bad++;
        $display("FAIL backpressure hold %0d: valid=%b out_pc=%h iaddr=%h, expected 1 0 8", k, out_valid, out_pc, iaddr);
      end
    end
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_instr !== imem[exp_pc[k] >> 2]) begin
        n_bad++;
        $display("FAIL backpressure release %0d: valid=%b out_pc=%h, expected 1 %h", k, out_valid, out_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_redirect();
    cyc(1'b1, 32'h40, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || iaddr !== 32'h40) begin
      n_bad++;
      $display("FAIL redirect flush: valid=%b iaddr=%h, expected 0 40", out_valid, iaddr);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== imem[16]) begin
      n_bad++;
      $display("FAIL redirect first beat: valid=%b pc=%h instr=%h, expected 1 40 %h", out_valid, out_pc, out_instr, imem[16]);
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b1, 32'h42, 1'b1);
    n_cmp++;
    if (fault !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned early fault: fault=%b, expected 0", fault);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned fault: fault=%b fault_pc=%h valid=%b, expected 1 42 0", fault, fault_pc, out_valid);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (iaddr !== 32'h42 || fault !== 1'b1) begin
      n_bad++;
      $display("FAIL fault hold: iaddr=%h fault=%b, expected 42 1", iaddr, fault);
    end
    cyc(1'b1, 32'h10, 1'b1);
    n_cmp++;
    if (fault !== 1'b0 || iaddr !== 32'h10) begin
      n_bad++;
      $display("FAIL fault clear: fault=%b iaddr=%h, expected 0 10", fault, iaddr);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
      n_bad++;
      $display("FAIL resume: valid=%b out_pc=%h, expected 1 10", out_valid, out_pc);
    end
  endtask

  task automatic test_range_end();
    cyc(1'b1, 32'h78, 1'b1);
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h78) begin
      n_bad++;
      $display("FAIL range beat 78: valid=%b out_pc=%h", out_valid, out_pc);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h7C || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL range beat 7C: valid=%b out_pc=%h fault=%b", out_valid, out_pc, fault);
    end
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h80 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL range fault: fault=%b fault_pc=%h valid=%b, expected 1 80 0", fault, fault_pc, out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || iaddr !== RESET_PC) begin
      n_bad++;
      $display("FAIL async reset: valid=%b fault=%b iaddr=%h, expected 0 0 %h", out_valid, fault, iaddr, RESET_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
      n_bad++;
      $display("FAIL post-reset beat: valid=%b out_pc=%h, expected 1 %h", out_valid, out_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 4))
        0:       rpc = 32'h7C;
        1:       rpc = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
        2:       rpc = 32'h80 + 32'($urandom_range(0, 15) * 4);
        default: rpc = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      cyc(rv, rpc, 1'($urandom_range(0, 3) != 0));
      n_cmp++;
      if (iaddr !== m_pc || out_valid !== (mq.size() > 0) || fault !== m_fault || fault_pc !== m_fpc ||
          (mq.size() > 0 && (out_pc !== mq[0].pc || out_instr !== mq[0].ins))) begin
        n_bad++;
        $display("FAIL random cycle %0d: iaddr=%h/%h valid=%b/%b fault=%b/%b fault_pc=%h/%h out_pc=%h/%h (actual/required)",
                 n, iaddr, m_pc, out_valid, mq.size() > 0, fault, m_fault, fault_pc, m_fpc,
                 out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      end
    end
  endtask

  initial begin
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_range_end();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives the fetch address to the combinational instruction memory each cycle.
- Captures the returned instruction and hands {pc, instr} to decode through a valid/ready handshake.
- Buffers up to 2 fetched instructions so decode backpressure never drops a fetch. Handles branch/jump redirects and misaligned or out-of-range fetch faults.

Parameters:
- WIDTH, 32, address and instruction width in bits.
- DEPTH, 32, instruction memory depth in words; word index ≥ DEPTH is out of range.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- iaddr  out  WIDTH  fetch byte address to instruction memory (combinational read, data valid same cycle)
- instr  in  WIDTH  instruction word returned for iaddr
- redir_valid  in  1  redirect request (branch/jump/trap), single-cycle pulse
- redir_pc  in  WIDTH  redirect target byte address
- out_valid  out  1  fetch buffer head holds a valid entry
- out_ready  in  1  decode accepts head entry this cycle
- out_pc  out  WIDTH  PC of head entry
- out_instr  out  WIDTH  instruction of head entry
- fault  out  1  fetch halted on a misaligned or out-of-range PC
- fault_pc  out  WIDTH  offending PC, held while fault=1

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=RUN, buffer empty, out_valid=0, out_pc=0, out_instr=0, fault=0, fault_pc=0. iaddr follows pc combinationally, so iaddr=RESET_PC.
- iaddr = pc at all times. No separate read enable; a fetch "fires" in a cycle when state=RUN, redir_valid=0, pc legal, and the buffer has space after this cycle's pop.
- Legal PC: pc[1:0]==0 and (pc>>2) < DEPTH.
- Fire: push {pc, instr} to buffer tail; pc <= pc+4 (mod 2^WIDTH). One instruction per cycle max; fetch-to-out_valid latency is 1 cycle.
- Buffer: 2-entry FIFO. Pop when out_valid && out_ready. Push and pop in the same cycle are allowed: a full buffer with a pop also permits a fire.
- out_* always reflect the head entry and stay stable while out_valid && !out_ready.
- States: RUN, FAULT.
  - RUN: if pc is illegal and there is no redirect, do not fire; go to FAULT with fault_pc <= pc. Entries already buffered still drain normally.
  - FAULT: fault=1, no fires, pc held.
- Redirect, any state: buffer flushed (a pop in the same cycle is ignored), pc <= redir_pc, fault=0, state <= RUN, and no fire that cycle. First fetch from the target happens next cycle, so first out_valid is 2 cycles after the redirect. Legality of redir_pc is evaluated next cycle, so an illegal target produces FAULT one cycle later.
- Reset mid-operation: immediate return to the reset state; buffered entries are discarded.
- Width rule: pc arithmetic is WIDTH bits, unsigned, with wrap-around; wrapped addresses are judged by the range check.

Decomposition:
- Shared package rv_pkg holds:
  - typedef fetch_entry_t {pc, instr}
  - enum fetch_state_t {RUN, FAULT}
  - constant INSTR_BYTES=4
- One sub-module, fetch_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush, count, full/empty.
- ifetch_unit holds the PC register, state machine and legality check.

Test Plan:
- Reset then out_ready=1 tied, imem words 0..3 = 0x11,0x22,0x33,0x44 → out_valid rises cycle 1; consecutive beats (0x0,0x11),(0x4,0x22),(0x8,0x33),(0xC,0x44); iaddr increments by 4 each cycle.
- out_ready=0 for 5 cycles after the first beat → buffer fills at 2 entries (pc 0x0, 0x4); iaddr holds 0x8; out_pc stays 0x0. After releasing out_ready → 0x8 follows 0x4 with no gap and no loss.
- redir_valid with redir_pc=0x40 while buffer holds 2 entries and out_ready=1 → both entries flushed, out_valid=0 next cycle, first beat out_pc=0x40 two cycles after the redirect.
- redir_pc=0x42 → one cycle later fault=1, fault_pc=0x42, out_valid=0, iaddr holds. A subsequent redirect to 0x10 → fault=0 and fetching resumes at 0x10.
- Sequential run from 0x78 with DEPTH=32 → beats 0x78 and 0x7C delivered, then fault=1 with fault_pc=0x80.
- rst_n asserted asynchronously mid-stream with 2 buffered entries → out_valid=0 and fault=0 immediately. After release, first beat out_pc=RESET_PC.
